// File: rtl/task_in_arb_pkg.sv
// ============================================================================
//  Module      : task_in_arb_pkg
//  Description : Shared state encoding and width helper for task_in_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package task_in_arb_pkg;

    typedef enum logic [1:0] {
        s_IDLE  = 2'd0,
        s_XFER  = 2'd1,
        s_FLUSH = 2'd2
    } arb_state_e;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : task_in_arb_pkg

`default_nettype wire

// File: rtl/task_in_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker; search starts one past the
//                last granted index and wraps. Returns one-hot grant + index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_idx_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;
    int               w_sum;

    always_comb begin
        grant_o = '0;
        idx_o   = last_idx_i;
        w_found = 1'b0;
        w_cand  = '0;
        w_sum   = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_sum = int'(last_idx_i) + i;
            if (w_sum >= NUM_PORTS) begin
                w_sum = w_sum - NUM_PORTS;
            end
            w_cand = IDX_W'(w_sum);
            if (!w_found && req_i[w_cand]) begin
                w_found         = 1'b1;
                grant_o[w_cand] = 1'b1;
                idx_o           = w_cand;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/task_in_arbiter.sv
// ============================================================================
//  Module      : task_in_arbiter
//  Description : Routes one upstream stream frame at a time to a round-robin
//                selected task-input port, capping frames at MAX_WORDS beats.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module task_in_arbiter
    import task_in_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORDS  = 243
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_tdata_valid,
    input  logic [DATA_WIDTH-1:0]                i_tdata,
    input  logic                                 i_tdata_last,
    output logic                                 o_tready,
    input  logic [NUM_PORTS-1:0]                 i_req,
    output logic [NUM_PORTS-1:0]                 o_grant,
    output logic [NUM_PORTS-1:0]                 o_tdata_valid,
    output logic [DATA_WIDTH-1:0]                o_tdata,
    output logic [NUM_PORTS-1:0]                 o_tdata_last,
    output logic                                 o_busy,
    output logic [clog2w(MAX_WORDS+1)-1:0]       o_word_cnt,
    output logic                                 o_overrun
);

    localparam int                 IDX_W      = clog2w(NUM_PORTS);
    localparam int                 CNT_W      = clog2w(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0]   CAP_CNT    = CNT_W'(MAX_WORDS - 1);
    localparam logic [IDX_W-1:0]   LAST_RESET = IDX_W'(NUM_PORTS - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       last_idx_q, last_idx_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic                   overrun_q, overrun_d;

    logic [NUM_PORTS-1:0]   w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_accept;
    logic                   w_cap;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req_i      (i_req),
        .last_idx_i (last_idx_q),
        .grant_o    (w_pick_grant),
        .idx_o      (w_pick_idx)
    );

    assign o_tready   = (state_q != s_IDLE);
    assign o_busy     = (state_q != s_IDLE);
    assign o_grant    = grant_q;
    assign o_tdata    = i_tdata;
    assign o_word_cnt = word_cnt_q;
    assign o_overrun  = overrun_q;

    assign w_accept = i_tdata_valid && o_tready;
    // The beat that would bring the count to MAX_WORDS.
    assign w_cap    = (word_cnt_q == CAP_CNT);

    always_comb begin
        o_tdata_valid = '0;
        o_tdata_last  = '0;
        if (state_q == s_XFER) begin
            o_tdata_valid = grant_q & {NUM_PORTS{i_tdata_valid}};
            o_tdata_last  = grant_q & {NUM_PORTS{i_tdata_last | (i_tdata_valid & w_cap)}};
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        word_cnt_d = word_cnt_q;
        overrun_d  = overrun_q;
        case (state_q)
            s_IDLE: begin
                if (i_req != '0) begin
                    grant_d    = w_pick_grant;
                    last_idx_d = w_pick_idx;
                    word_cnt_d = '0;
                    state_d    = s_XFER;
                end
            end
            s_XFER: begin
                if (w_accept) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (i_tdata_last) begin
                        grant_d = '0;
                        state_d = s_IDLE;
                    end else if (w_cap) begin
                        grant_d   = '0;
                        overrun_d = 1'b1;
                        state_d   = s_FLUSH;
                    end
                end
            end
            s_FLUSH: begin
                if (w_accept && i_tdata_last) begin
                    state_d = s_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = s_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= s_IDLE;
            grant_q    <= '0;
            last_idx_q <= LAST_RESET;
            word_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            word_cnt_q <= word_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule : task_in_arbiter

`default_nettype wire

// File: tb/tb_task_in_arbiter.sv
// ============================================================================
//  Module      : tb_task_in_arbiter
//  Description : Scoreboard bench for task_in_arbiter (default and MAX_WORDS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_task_in_arbiter;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_tdata_valid = 1'b0;
    logic [7:0] i_tdata = 8'h00;
    logic       i_tdata_last = 1'b0;
    logic [3:0] i_req = 4'b0000;

    logic       o_tready, o_busy, o_overrun;
    logic [3:0] o_grant, o_tdata_valid, o_tdata_last;
    logic [7:0] o_tdata, o_word_cnt;

    logic       o_tready4, o_busy4, o_overrun4;
    logic [3:0] o_grant4, o_tdata_valid4, o_tdata_last4;
    logic [7:0] o_tdata4;
    logic [2:0] o_word_cnt4;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 i_clk = ~i_clk;

    task_in_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tdata_valid(i_tdata_valid),
        .i_tdata(i_tdata), .i_tdata_last(i_tdata_last), .o_tready(o_tready),
        .i_req(i_req), .o_grant(o_grant), .o_tdata_valid(o_tdata_valid),
        .o_tdata(o_tdata), .o_tdata_last(o_tdata_last), .o_busy(o_busy),
        .o_word_cnt(o_word_cnt), .o_overrun(o_overrun)
    );

    task_in_arbiter #(.MAX_WORDS(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tdata_valid(i_tdata_valid),
        .i_tdata(i_tdata), .i_tdata_last(i_tdata_last), .o_tready(o_tready4),
        .i_req(i_req), .o_grant(o_grant4), .o_tdata_valid(o_tdata_valid4),
        .o_tdata(o_tdata4), .o_tdata_last(o_tdata_last4), .o_busy(o_busy4),
        .o_word_cnt(o_word_cnt4), .o_overrun(o_overrun4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every delivered beat on the default instance is matched in order.
    always @(negedge i_clk) begin
        if (o_tdata_valid != 4'b0000) begin
            int    p;
            beat_t e;
            p = 0;
            for (int i = 0; i < 4; i++) if (o_tdata_valid[i]) p = i;
            chk("valid_onehot", 32'($onehot(o_tdata_valid)), 1);
            chk("last_outside_valid", o_tdata_last & ~o_tdata_valid, 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", o_tdata_valid, 0);
            end else begin
                e = sb_q.pop_front();
                chk("beat_port", p, e.port);
                chk("beat_data", o_tdata, e.data);
                chk("beat_last", o_tdata_last[p], e.last);
            end
        end
    end

    task automatic wait_grant(input logic [3:0] exp_grant, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge i_clk); #1;
            if (o_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", o_tready, 1);
        else begin
            chk("grant", o_grant, exp_grant);
            chk("busy_in_frame", o_busy, 1);
        end
    endtask

    // k4 > 0 also checks the MAX_WORDS=4 instance for beat number k4.
    task automatic drive_beat(input int port, input logic [7:0] data, input logic last, input int k4);
        i_tdata_valid = 1'b1;
        i_tdata       = data;
        i_tdata_last  = last;
        sb_q.push_back('{port: 2'(port), data: data, last: last});
        #1;
        if (k4 > 0) begin
            chk("cap_valid", o_tdata_valid4, (k4 <= 4) ? 4'b0001 : 4'b0000);
            chk("cap_last", o_tdata_last4, (k4 == 4) ? 4'b0001 : 4'b0000);
            chk("cap_tready", o_tready4, 1);
            if (k4 > 4) chk("cap_cnt_held", o_word_cnt4, 4);
        end
        @(posedge i_clk); #1;
        i_tdata_valid = 1'b0;
        i_tdata_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] req, input logic [3:0] exp_grant,
                              input int port, input int nbeats, input logic [7:0] base,
                              input bit stall, input bit drop_req, input bit keep_req,
                              input bit cap_chk);
        bit ok;
        i_req = req;
        wait_grant(exp_grant, ok);
        if (ok) begin
            for (int b = 0; b < nbeats; b++) begin
                if (stall && b > 0) begin
                    @(posedge i_clk); #1;
                end
                drive_beat(port, base + 8'(b), b == nbeats - 1, cap_chk ? b + 1 : 0);
                if (drop_req && b == 0) i_req = 4'b0000;
            end
            chk("idle_gap_tready", o_tready, 0);
            chk("idle_busy", o_busy, 0);
            chk("idle_grant", o_grant, 0);
            chk("frame_word_cnt", o_word_cnt, nbeats);
        end
        if (!keep_req) i_req = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        #12;
        chk("rst_tready", o_tready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_word_cnt", o_word_cnt, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_valid", o_tdata_valid | o_tdata_last, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // All ports requesting: strict rotation, wrapping back to port 0.
        send_frame(4'b1111, 4'b0001, 0, 3, 8'h20, 0, 0, 1, 0);
        send_frame(4'b1111, 4'b0010, 1, 3, 8'h30, 0, 0, 1, 0);
        send_frame(4'b1111, 4'b0100, 2, 3, 8'h40, 0, 0, 1, 0);
        send_frame(4'b1111, 4'b1000, 3, 3, 8'h50, 0, 0, 1, 0);
        send_frame(4'b1111, 4'b0001, 0, 3, 8'h60, 0, 0, 0, 0);

        // Single requester, 5-beat frame.
        send_frame(4'b0001, 4'b0001, 0, 5, 8'h10, 0, 0, 0, 0);
        chk("overrun_small_frames", o_overrun, 0);
        chk("cap_overrun_set_early", o_overrun4, 1);

        // Stalled beats do not count or end the frame.
        send_frame(4'b0010, 4'b0010, 1, 4, 8'h70, 1, 0, 0, 0);

        // Request dropped after first beat; grant holds.
        send_frame(4'b0100, 4'b0100, 2, 4, 8'h80, 0, 1, 0, 0);

        // Reset in the middle of a frame.
        i_req = 4'b1000;
        wait_grant(4'b1000, ok);
        drive_beat(3, 8'h90, 1'b0, 0);
        drive_beat(3, 8'h91, 1'b0, 0);
        i_req = 4'b0000;
        chk("mid_frame_cnt", o_word_cnt, 2);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_tready", o_tready, 0);
        chk("async_grant", o_grant, 0);
        chk("async_word_cnt", o_word_cnt, 0);
        chk("async_busy", o_busy, 0);
        chk("async_cap_overrun", o_overrun4, 0);
        chk("async_cap_tready", o_tready4, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Post-reset grant restarts at port 0; 6-beat frame overruns the capped instance.
        send_frame(4'b1111, 4'b0001, 0, 6, 8'hA0, 0, 0, 0, 1);
        chk("cap_overrun", o_overrun4, 1);
        chk("cap_word_cnt", o_word_cnt4, 4);
        chk("cap_idle_tready", o_tready4, 0);
        chk("nocap_overrun", o_overrun, 0);

        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_task_in_arbiter

`default_nettype wire

// File: doc/task_in_arbiter.md
TASK_IN_ARBITER -- requirements
Module: task_in_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of downstream task-input requesters.
REQ-002 Parameter DATA_WIDTH, default 8: stream data width.
REQ-003 Parameter MAX_WORDS, default 243: maximum beats per frame.
REQ-004 Ports, one per line (name  direction  width  meaning). One clock; reset is asynchronous and active-low.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tdata_valid  in  1  upstream beat valid.
- i_tdata  in  DATA_WIDTH  upstream beat data.
- i_tdata_last  in  1  upstream end of frame.
- o_tready  out  1  upstream ready.
- i_req  in  NUM_PORTS  per-port frame request (port's tready).
- o_grant  out  NUM_PORTS  one-hot current owner.
- o_tdata_valid  out  NUM_PORTS  per-port beat valid.
- o_tdata  out  DATA_WIDTH  shared data, equals i_tdata.
- o_tdata_last  out  NUM_PORTS  per-port end of frame.
- o_busy  out  1  frame in progress.
- o_word_cnt  out  clog2(MAX_WORDS+1)  beats accepted in current frame.
- o_overrun  out  1  sticky: a frame exceeded MAX_WORDS.

Function
REQ-005 FSM states: s_IDLE, s_XFER, s_FLUSH; accepted beat = i_tdata_valid && o_tready.
REQ-006 s_IDLE: if i_req != 0, register one-hot o_grant from round-robin pick, clear o_word_cnt, go s_XFER next cycle; else stay.
REQ-007 Round-robin: search starts at index after last granted port, wrapping at NUM_PORTS-1 to 0; after reset search starts at port 0.
REQ-008 o_tready = 1 exactly in s_XFER and s_FLUSH; 0 in s_IDLE.
REQ-009 In s_XFER, o_tdata_valid[g] = i_tdata_valid and o_tdata_last[g] = i_tdata_last for granted g, zero latency; all other bits 0.
REQ-010 Each accepted beat in s_XFER increments o_word_cnt by 1 on next edge.
REQ-011 Accepted beat with i_tdata_last in s_XFER: o_grant clears, state s_IDLE next cycle; minimum one idle cycle between frames.
REQ-012 Accepted beat number MAX_WORDS without i_tdata_last: o_tdata_last[g] forced 1 on that beat, o_overrun set, state s_FLUSH.
REQ-013 s_FLUSH: o_grant = 0, beats accepted and dropped (no o_tdata_valid), o_word_cnt held; accepted i_tdata_last returns to s_IDLE.
REQ-014 Deassertion of i_req[g] during s_XFER ignored; grant held until frame end (no frame splitting).
REQ-015 Requests arriving during s_XFER/s_FLUSH wait; evaluated in next s_IDLE cycle.
REQ-016 o_busy = 1 in s_XFER and s_FLUSH.
REQ-017 o_overrun cleared only by reset.
REQ-018 o_tdata always equals i_tdata (no register).

Reset
REQ-019 i_rst_n low asynchronously forces: state s_IDLE, o_grant 0, o_word_cnt 0, o_overrun 0, last-granted pointer NUM_PORTS-1; hence o_tready 0, o_busy 0, all per-port valid/last 0.
REQ-020 Reset mid-frame abandons frame; no partial-frame recovery after release.
REQ-021 Reset released synchronously to i_clk; first arbitration on first edge after release.

Structure
REQ-022 Package task_in_arb_pkg holds the state enum and a clog2 width function.
REQ-023 Sub-module rr_pick: combinational round-robin one-hot picker (inputs req, last pointer; output one-hot grant and index).
REQ-024 All sequential logic in task_in_arbiter; target 150-300 RTL lines.

Verification
REQ-025 i_req=4'b0001, 5-beat frame 0x10..0x14 with last on beat 5 -> o_grant=0001, port 0 receives 5 beats, o_tdata_last[0] on beat 5, o_word_cnt=5, s_IDLE after.
REQ-026 i_req=4'b1111 held, four 3-beat frames -> grants 0001,0010,0100,1000 in order, then 0001 again.
REQ-027 MAX_WORDS=4, 6-beat frame -> port sees 4 beats with last on beat 4, o_overrun=1, beats 5-6 dropped, return to s_IDLE after beat 6.
REQ-028 i_tdata_valid toggled 1/0 during frame -> o_word_cnt counts only accepted beats; stalls do not end frame.
REQ-029 i_req[2] dropped mid-frame -> grant held, remaining beats delivered to port 2.
REQ-030 i_rst_n pulsed low mid-frame -> o_tready, o_grant, o_word_cnt, o_overrun 0 immediately (no clock edge); next grant goes to port 0.
